// File: rtl/output_mems.sv
// Result buffer: collects C-matrix elements from the compute side, then streams them out in
// row-major order over AXI-Stream. Define OUTPUT_MEMS_TLAST_EN to build the AXIS_TLAST port.
module output_mems #(
  parameter int unsigned OUTW = 24,
  parameter int unsigned M    = 7,
  parameter int unsigned N    = 9,
  localparam int unsigned C_ADDR_BITS = $clog2(M * N)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   C_wr_en,
  input  logic [C_ADDR_BITS-1:0] C_wr_addr,
  input  logic [OUTW-1:0]        C_wr_data,
  input  logic                   compute_finished,
  output logic                   results_ready,
  output logic [OUTW-1:0]        AXIS_TDATA,
  output logic                   AXIS_TVALID,
`ifdef OUTPUT_MEMS_TLAST_EN
  output logic                   AXIS_TLAST,
`endif
  input  logic                   AXIS_TREADY
);

  localparam int unsigned DEPTH    = M * N;
  // One extra count value marks "every element has been read".
  localparam int unsigned CNT_BITS = $clog2(DEPTH + 1);
  localparam logic [CNT_BITS-1:0] LastIdx = CNT_BITS'(DEPTH - 1);
  localparam logic [CNT_BITS-1:0] EndIdx  = CNT_BITS'(DEPTH);

  localparam logic [0:0] StLoad   = 1'b0;
  localparam logic [0:0] StStream = 1'b1;

  logic [OUTW-1:0]     mem_q [DEPTH];
  logic [0:0]          state_q, state_d;
  logic [CNT_BITS-1:0] rd_cnt_q, rd_cnt_d;
  logic                tvalid_q, tvalid_d;
  logic [OUTW-1:0]     tdata_q;
  logic                wr_in_range;
  logic                mem_we;
  logic                rd_issue;
  logic                xfer;

  always_comb begin
    wr_in_range = CNT_BITS'(C_wr_addr) < EndIdx;
    mem_we      = (state_q == StLoad) && C_wr_en && wr_in_range;
    xfer        = tvalid_q && AXIS_TREADY;
    // The read register doubles as the output stage: refill it when empty or being drained,
    // so a continuously ready sink sees one element per cycle.
    rd_issue    = (state_q == StStream) && (rd_cnt_q != EndIdx) && (!tvalid_q || AXIS_TREADY);

    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    tvalid_d = tvalid_q;

    if (state_q == StLoad) begin
      if (compute_finished) begin
        state_d  = StStream;
        rd_cnt_d = '0;
      end
    end else begin
      if (rd_issue) begin
        rd_cnt_d = rd_cnt_q + CNT_BITS'(1);
        tvalid_d = 1'b1;
      end else if (xfer) begin
        // Only reachable once the final element is being accepted.
        tvalid_d = 1'b0;
        state_d  = StLoad;
        rd_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StLoad;
      rd_cnt_q <= '0;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      tvalid_q <= tvalid_d;
    end
  end

  // Storage is deliberately not reset so results survive across frames and resets.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[C_wr_addr] <= C_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tdata_q <= '0;
    end else if (rd_issue) begin
      tdata_q <= mem_q[rd_cnt_q[C_ADDR_BITS-1:0]];
    end
  end

`ifdef OUTPUT_MEMS_TLAST_EN
  logic tlast_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tlast_q <= 1'b0;
    end else if (rd_issue) begin
      tlast_q <= (rd_cnt_q == LastIdx);
    end else if (xfer) begin
      tlast_q <= 1'b0;
    end
  end

  assign AXIS_TLAST = tlast_q;
`endif

  assign results_ready = (state_q == StLoad);
  assign AXIS_TDATA    = tdata_q;
  assign AXIS_TVALID   = tvalid_q;

endmodule

// File: tb/tb_output_mems.sv
// Directed/randomized bench for output_mems; a plain array holds the expected RAM image and
// every streamed element is compared against it in order.
module tb_output_mems;

  localparam int unsigned OUTW  = 24;
  localparam int unsigned M     = 7;
  localparam int unsigned N     = 9;
  localparam int unsigned DEPTH = M * N;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            C_wr_en = 1'b0;
  logic [AW-1:0]   C_wr_addr = '0;
  logic [OUTW-1:0] C_wr_data = '0;
  logic            compute_finished = 1'b0;
  logic            results_ready;
  logic [OUTW-1:0] AXIS_TDATA;
  logic            AXIS_TVALID;
  logic            AXIS_TREADY = 1'b0;
`ifdef OUTPUT_MEMS_TLAST_EN
  logic            AXIS_TLAST;
`endif

  int tests = 0;
  int fails = 0;

  logic [OUTW-1:0] ref_mem [DEPTH];

  output_mems #(.OUTW(OUTW), .M(M), .N(N)) dut (
    .clk              (clk),
    .reset            (reset),
    .C_wr_en          (C_wr_en),
    .C_wr_addr        (C_wr_addr),
    .C_wr_data        (C_wr_data),
    .compute_finished (compute_finished),
    .results_ready    (results_ready),
    .AXIS_TDATA       (AXIS_TDATA),
    .AXIS_TVALID      (AXIS_TVALID),
`ifdef OUTPUT_MEMS_TLAST_EN
    .AXIS_TLAST       (AXIS_TLAST),
`endif
    .AXIS_TREADY      (AXIS_TREADY)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference memory: only in-range writes land, nothing wraps.
  task automatic model_write(input bit wr, input int addr, input logic [OUTW-1:0] data);
    if (wr && addr >= 0 && addr < int'(DEPTH)) ref_mem[addr] = data;
  endtask

  task automatic write_word(input int addr, input logic [OUTW-1:0] data);
    check("load_ready", results_ready, 1);
    C_wr_en   = 1'b1;
    C_wr_addr = AW'(addr);
    C_wr_data = data;
    model_write(1'b1, addr, data);
    tick();
    C_wr_en = 1'b0;
  endtask

  // Pulse compute_finished in cycle t (optionally with a write) and land in cycle t+2.
  task automatic pulse_finish(input bit wr, input int addr, input logic [OUTW-1:0] data);
    check("ready_at_t", results_ready, 1);
    C_wr_en          = wr;
    C_wr_addr        = AW'(addr);
    C_wr_data        = data;
    compute_finished = 1'b1;
    model_write(wr, addr, data);
    tick();
    C_wr_en          = 1'b0;
    compute_finished = 1'b0;
    check("ready_t1", results_ready, 0);
    check("valid_t1", AXIS_TVALID, 0);
    tick();
    check("valid_t2", AXIS_TVALID, 1);
    check("first_data", AXIS_TDATA, ref_mem[0]);
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready.
  task automatic stream_frame(input int mode, input bit inject);
    int idx = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    bit rdy;
    logic [OUTW-1:0] held = '0;
    while (idx < int'(DEPTH) && cyc < 2000) begin
      if (stalled) begin
        check("stall_valid", AXIS_TVALID, 1);
        check("stall_data", AXIS_TDATA, held);
      end
      if (mode == 0) check("no_bubble", AXIS_TVALID, 1);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (inject && cyc == 10) begin
        C_wr_en          = 1'b1;
        C_wr_addr        = '0;
        C_wr_data        = OUTW'(999);
        compute_finished = 1'b1;
      end else begin
        C_wr_en          = 1'b0;
        compute_finished = 1'b0;
      end
      AXIS_TREADY = rdy;
`ifdef OUTPUT_MEMS_TLAST_EN
      check("tlast", AXIS_TLAST, AXIS_TVALID && (idx == int'(DEPTH) - 1));
`endif
      if (AXIS_TVALID && rdy) begin
        check("stream_data", AXIS_TDATA, ref_mem[idx]);
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = AXIS_TVALID;
        held    = AXIS_TDATA;
      end
      tick();
      cyc++;
    end
    C_wr_en          = 1'b0;
    compute_finished = 1'b0;
    check("frame_count", idx, DEPTH);
    if (mode == 0) check("frame_cycles", cyc, DEPTH);
    check("valid_drop", AXIS_TVALID, 0);
    check("ready_back", results_ready, 1);
    AXIS_TREADY = 1'b1;
    repeat (4) begin
      tick();
      check("no_extra_frame", AXIS_TVALID, 0);
    end
  endtask

  initial begin
    tick();
    tick();
    check("rst_ready", results_ready, 1);
    check("rst_valid", AXIS_TVALID, 0);
    check("rst_data", AXIS_TDATA, 0);
    reset = 1'b0;
    tick();

    // Frame 1: C[i] = i + 100, always ready.
    for (int i = 0; i < int'(DEPTH); i++) write_word(i, OUTW'(i + 100));
    pulse_finish(1'b0, 0, '0);
    stream_frame(0, 1'b0);

    // Frame 2: same contents, ready pattern 1,0,0,1.
    pulse_finish(1'b0, 0, '0);
    stream_frame(1, 1'b0);

    // Frame 3: random overwrites (some out of range), writes/finish injected mid-stream.
    for (int i = 0; i < 20; i++) begin
      write_word(int'($urandom_range(0, 63)), OUTW'($urandom));
    end
    pulse_finish(1'b0, 0, '0);
    stream_frame(2, 1'b1);

    // Frame 4: out-of-range write, then a write coinciding with the finish pulse.
    write_word(63, OUTW'(24'hABCDEF));
    pulse_finish(1'b1, 0, OUTW'(5));
    check("first_is_5", AXIS_TDATA, 5);
    stream_frame(2, 1'b0);

    // Reset while element 30 is stalled; RAM must survive.
    pulse_finish(1'b0, 0, '0);
    AXIS_TREADY = 1'b1;
    for (int k = 0; k < 30; k++) tick();
    AXIS_TREADY = 1'b0;
    check("pre_rst_elem30", AXIS_TDATA, ref_mem[30]);
    tick();
    check("stall_elem30", AXIS_TDATA, ref_mem[30]);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_valid", AXIS_TVALID, 0);
    check("mid_rst_ready", results_ready, 1);
    check("mid_rst_data", AXIS_TDATA, 0);
    tick();
    check("post_rst_idle", AXIS_TVALID, 0);
    pulse_finish(1'b0, 0, '0);
    stream_frame(2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
